frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of each frame word.
REQ-002 SHALL have parameter N_FRAMES, default 16, number of frame words per block; index width IDX_W = log2(N_FRAMES) = 4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  request to capture one frame block.
REQ-006 Small_or_Big  input  1  mode qualifier; a load is honoured only when 1.
REQ-007 frame_0_in .. frame_15_in  input  WORD_W each  parallel frame words, sampled on an accepted load.
REQ-008 abort  input  1  cancel transmission in progress.
REQ-009 out_ready  input  1  downstream can accept a word this cycle.
REQ-010 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-011 out_data  output  WORD_W  current frame word.
REQ-012 out_idx  output  IDX_W  index of current word, 0..N_FRAMES-1.
REQ-013 out_last  output  1  current word is index N_FRAMES-1.
REQ-014 busy  output  1  block held in buffer, not yet fully sent.
REQ-015 done  output  1  one-cycle pulse after final word handshake.
REQ-016 overrun  output  1  sticky: load arrived while busy.
REQ-017 blocks_sent  output  8  count of fully transmitted blocks.

Function
REQ-018 SHALL implement two states, IDLE and SEND; all outputs registered.
REQ-019 Accepted load = load=1 and Small_or_Big=1 in IDLE; at that edge all N_FRAMES words SHALL be captured into an internal buffer, index SHALL be set to 0, and state SHALL go to SEND.
REQ-020 load with Small_or_Big=0 SHALL be ignored in every state: no capture, no flag change.
REQ-021 Latency: accepted load at edge k -> out_valid=1, out_idx=0, out_data=frame_0_in (as sampled at k) from edge k.
REQ-022 In SEND, out_valid SHALL be 1, out_data=buffer[index], out_idx=index, out_last=(index==N_FRAMES-1), busy=1.
REQ-023 Handshake = out_valid and out_ready at a rising edge; without it out_data/out_idx/out_last SHALL hold stable.
REQ-024 Handshake with index<N_FRAMES-1 SHALL increment index by 1; one word per cycle when out_ready held high.
REQ-025 Handshake with index==N_FRAMES-1 SHALL return to IDLE, clear out_valid/out_last/busy, pulse done=1 for exactly one cycle, increment blocks_sent.
REQ-026 blocks_sent SHALL wrap 255 -> 0.
REQ-027 Qualified load (Small_or_Big=1) while in SEND SHALL NOT alter buffer or index and SHALL set overrun=1, including the cycle of the final handshake.
REQ-028 overrun SHALL clear only on the next accepted load or on reset.
REQ-029 abort=1 in SEND SHALL return to IDLE at that edge: out_valid=0, busy=0, no done pulse, blocks_sent unchanged; abort takes priority over a simultaneous handshake.
REQ-030 abort in IDLE SHALL have no effect; abort and accepted load in the same IDLE cycle: load wins.
REQ-031 Buffer contents SHALL be unchanged in IDLE; out_data SHALL read 0 in IDLE.

Reset
REQ-032 rst=1 SHALL immediately, independent of clk, force IDLE, index=0, buffer=0, and out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, overrun=0, blocks_sent=0.
REQ-033 Reset asserted mid-SEND SHALL discard the block with no done pulse; first edge after release with accepted load SHALL behave per REQ-019.

Verification
REQ-034 Load frame_i_in=0xA0000000+i, Small_or_Big=1, out_ready=1 -> 16 consecutive words 0xA0000000..0xA000000F, out_idx 0..15, out_last only on 15, done one cycle after word 15, blocks_sent=1.
REQ-035 Same load, out_ready toggled 1,0,1,0 -> each word held while out_ready=0, no word skipped or duplicated, done after 16th handshake (32 cycles).
REQ-036 Load with Small_or_Big=0 -> out_valid stays 0, busy 0, buffer unchanged; then Small_or_Big=1 -> transmission starts at idx 0.
REQ-037 Qualified load at idx 5 with new data 0xFFFFFFFF -> words 6..15 remain original values, overrun=1 held until next accepted load.
REQ-038 abort at idx 7 -> out_valid=0 next cycle, no done, blocks_sent unchanged; rst pulse at idx 3 of a second block -> all outputs 0 asynchronously.
REQ-039 256 complete blocks -> blocks_sent wraps to 0.

Source files
------------

// File: rtl/frame_serializer.sv
// Frame serializer: captures a block of N_FRAMES parallel words on a qualified load and
// streams them one word per ready/valid handshake, with abort, overrun flag and block count.
module frame_serializer #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned N_FRAMES = 16,
  localparam int unsigned IDX_W   = $clog2(N_FRAMES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              Small_or_Big,
  input  logic [WORD_W-1:0] frame_0_in,
  input  logic [WORD_W-1:0] frame_1_in,
  input  logic [WORD_W-1:0] frame_2_in,
  input  logic [WORD_W-1:0] frame_3_in,
  input  logic [WORD_W-1:0] frame_4_in,
  input  logic [WORD_W-1:0] frame_5_in,
  input  logic [WORD_W-1:0] frame_6_in,
  input  logic [WORD_W-1:0] frame_7_in,
  input  logic [WORD_W-1:0] frame_8_in,
  input  logic [WORD_W-1:0] frame_9_in,
  input  logic [WORD_W-1:0] frame_10_in,
  input  logic [WORD_W-1:0] frame_11_in,
  input  logic [WORD_W-1:0] frame_12_in,
  input  logic [WORD_W-1:0] frame_13_in,
  input  logic [WORD_W-1:0] frame_14_in,
  input  logic [WORD_W-1:0] frame_15_in,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [7:0]        blocks_sent
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_FRAMES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] frame_in [N_FRAMES];
  logic [WORD_W-1:0] buf_q    [N_FRAMES];
  logic [WORD_W-1:0] buf_d    [N_FRAMES];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        blocks_q, blocks_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic qload, accept, hs, final_hs;

  // Port list is fixed at 16 words; N_FRAMES must stay 16.
  assign frame_in[0]  = frame_0_in;
  assign frame_in[1]  = frame_1_in;
  assign frame_in[2]  = frame_2_in;
  assign frame_in[3]  = frame_3_in;
  assign frame_in[4]  = frame_4_in;
  assign frame_in[5]  = frame_5_in;
  assign frame_in[6]  = frame_6_in;
  assign frame_in[7]  = frame_7_in;
  assign frame_in[8]  = frame_8_in;
  assign frame_in[9]  = frame_9_in;
  assign frame_in[10] = frame_10_in;
  assign frame_in[11] = frame_11_in;
  assign frame_in[12] = frame_12_in;
  assign frame_in[13] = frame_13_in;
  assign frame_in[14] = frame_14_in;
  assign frame_in[15] = frame_15_in;

  assign qload    = load && Small_or_Big;
  assign accept   = (state_q == StIdle) && qload;
  // Abort outranks a simultaneous handshake.
  assign hs       = (state_q == StSend) && out_ready && !abort;
  assign final_hs = hs && (idx_q == LastIdx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: if (abort || final_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_d     = buf_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    blocks_d  = blocks_q + 8'(final_hs);
    done_d    = final_hs;
    if (accept) begin
      buf_d     = frame_in;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else if (state_q == StSend) begin
      if (qload) overrun_d = 1'b1;
      if (abort || final_hs) idx_d = '0;
      else if (hs)           idx_d = idx_q + IDX_W'(1);
    end
    valid_d = (state_d == StSend);
    data_d  = valid_d ? buf_d[idx_d] : '0;
    last_d  = valid_d && (idx_d == LastIdx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FRAMES; i++) buf_q[i] <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      blocks_q  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      blocks_q  <= blocks_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;
  assign busy        = valid_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign blocks_sent = blocks_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: directed scenarios plus random traffic, checked by a
// block-level reference model feeding an expected-word queue drained by a monitor.
module tb_frame_serializer;

  logic        clk = 1'b0;
  logic        rst, load, sob, abort, out_ready;
  logic [31:0] frm [16];
  logic        out_valid, out_last, busy, done, overrun;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic [7:0]  blocks_sent;

  always #5 clk = ~clk;

  frame_serializer dut (
    .clk(clk), .rst(rst), .load(load), .Small_or_Big(sob),
    .frame_0_in(frm[0]),   .frame_1_in(frm[1]),   .frame_2_in(frm[2]),   .frame_3_in(frm[3]),
    .frame_4_in(frm[4]),   .frame_5_in(frm[5]),   .frame_6_in(frm[6]),   .frame_7_in(frm[7]),
    .frame_8_in(frm[8]),   .frame_9_in(frm[9]),   .frame_10_in(frm[10]), .frame_11_in(frm[11]),
    .frame_12_in(frm[12]), .frame_13_in(frm[13]), .frame_14_in(frm[14]), .frame_15_in(frm[15]),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .overrun(overrun),
    .blocks_sent(blocks_sent)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is a list of words; the stream is that list in order.
  typedef struct packed {logic [31:0] data; logic [3:0] idx;} exp_t;
  exp_t exp_q[$];
  bit   m_sending, m_done, m_ovr;
  int   m_pos, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_sending = 0; m_done = 0; m_ovr = 0; m_pos = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (!m_sending) begin
        if (load && sob) begin
          for (int i = 0; i < 16; i++) exp_q.push_back('{data: frm[i], idx: 4'(i)});
          m_sending = 1; m_pos = 0; m_ovr = 0;
        end
      end else begin
        if (load && sob) m_ovr = 1;
        if (abort) begin
          m_sending = 0; m_pos = 0;
          exp_q.delete();
        end else if (out_ready) begin
          m_pos++;
          if (m_pos == 16) begin
            m_sending = 0; m_pos = 0; m_done = 1;
            m_cnt = (m_cnt + 1) % 256;
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops one expected word per handshake.
  bit          hold_pend = 0;
  logic [31:0] hold_data;
  logic [3:0]  hold_idx;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
    end else begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_sending});
      check("busy", {31'd0, busy}, {31'd0, m_sending});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      check("blocks_sent", {24'd0, blocks_sent}, 32'(m_cnt));
      if (out_valid) begin
        if (hold_pend) begin
          check("hold_data", out_data, hold_data);
          check("hold_idx", {28'd0, out_idx}, {28'd0, hold_idx});
        end
        if (out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_idx", {28'd0, out_idx}, {28'd0, e.idx});
            check("out_last", {31'd0, out_last}, {31'd0, e.idx == 4'd15});
          end
        end
      end else begin
        check("idle_data", out_data, 32'd0);
        check("idle_last", {31'd0, out_last}, 32'd0);
      end
      hold_pend = out_valid && !out_ready && !abort;
      hold_data = out_data;
      hold_idx  = out_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frames(input logic [31:0] base);
    for (int i = 0; i < 16; i++) frm[i] = base + 32'(i);
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (!(m_sending && m_pos == p) && k < 64) begin
      tick();
      k++;
    end
    check("wait_pos_timeout", 32'(k >= 64), 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_sending && k < 100) begin
      tick();
      k++;
    end
    check("wait_idle_timeout", 32'(k >= 100), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_idx"}, {28'd0, out_idx}, 32'd0);
    check({tag, "_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_blocks"}, {24'd0, blocks_sent}, 32'd0);
  endtask

  task automatic pulse_load();
    load = 1; tick(); load = 0;
  endtask

  initial begin
    rst = 1; load = 0; sob = 1; abort = 0; out_ready = 1;
    set_frames(32'h0);
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst = 0;
    tick();

    // Straight block with ready held high.
    set_frames(32'hA000_0000);
    pulse_load();
    repeat (17) tick();
    check("blk1_count", {24'd0, blocks_sent}, 32'd1);

    // Ready toggling 1,0,1,0: each word held while not ready.
    pulse_load();
    for (int i = 0; i < 40 && m_sending; i++) begin
      out_ready = ~out_ready;
      if (i == 0) out_ready = 0;
      tick();
    end
    wait_idle();
    out_ready = 1;
    check("toggle_count", {24'd0, blocks_sent}, 32'd2);

    // Unqualified load ignored, then a qualified one starts at idx 0.
    set_frames(32'h5555_0000);
    sob = 0; load = 1;
    repeat (3) tick();
    load = 0; sob = 1;
    tick();
    set_frames(32'hA000_0000);
    pulse_load();
    wait_idle();

    // Qualified load mid-block: no effect on stream, overrun latched.
    pulse_load();
    wait_pos(5);
    set_frames(32'hFFFF_FFFF);
    pulse_load();
    wait_idle();
    repeat (3) tick();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    set_frames(32'hA000_0000);
    pulse_load();
    wait_idle();

    // Abort at idx 7, then reset mid-block at idx 3.
    pulse_load();
    wait_pos(7);
    abort = 1; tick(); abort = 0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    tick();
    pulse_load();
    wait_pos(3);
    rst = 1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 0;
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(7) == 0);
      sob       = ($urandom_range(3) != 0);
      abort     = ($urandom_range(40) == 0);
      out_ready = ($urandom_range(2) != 0);
      for (int j = 0; j < 16; j++) frm[j] = $urandom;
      tick();
    end
    load = 0; abort = 0; out_ready = 1; sob = 1;
    wait_idle();

    // 256 blocks from reset wrap the counter to zero.
    rst = 1; tick(); rst = 0; tick();
    for (int b = 0; b < 256; b++) begin
      set_frames(32'(b) << 8);
      pulse_load();
      repeat (16) tick();
    end
    tick();
    check("wrap_count", {24'd0, blocks_sent}, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
